// File: rtl/task_scheduler_pkg.sv
// rtl/task_scheduler_pkg.sv - shared opcodes, FSM states and op-word layout for the task scheduler
package task_scheduler_pkg;

   localparam logic [3:0] OP_READY    = 4'b0001;
   localparam logic [3:0] OP_SUSPEND  = 4'b0010;
   localparam logic [3:0] OP_WAIT     = 4'b0011;
   localparam logic [3:0] OP_KILL     = 4'b0100;
   localparam logic [3:0] OP_SET_PRIO = 4'b0101;
   localparam logic [3:0] OP_SET_HIT  = 4'b0110;
   localparam logic [3:0] OP_EXECUTE  = 4'b0111;
   localparam logic [3:0] OP_FINISH   = 4'b1111;

   // op word = {4'h0, id, opcode, arg}
   localparam int OP_ID_LSB   = 8;
   localparam int OP_CODE_LSB = 4;
   localparam int OP_ARG_LSB  = 0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SELECT,
      ST_DISPATCH,
      ST_RUN,
      ST_FINISH
   } state_t;

   function automatic logic [15:0] make_op(input logic [3:0] id, input logic [3:0] code,
                                           input logic [3:0] arg);
      logic [15:0] w;
      w = 16'h0000;
      w[OP_ID_LSB +: 4]   = id;
      w[OP_CODE_LSB +: 4] = code;
      w[OP_ARG_LSB +: 4]  = arg;
      return w;
   endfunction

endpackage

// File: rtl/task_scheduler_prio_rr_select.sv
// rtl/task_scheduler_prio_rr_select.sv - combinational max-priority picker with round-robin tie break
module prio_rr_select #(
   parameter int N_TASKS = 8,
   parameter int SW      = $clog2(N_TASKS)
) (
   input  logic [8*N_TASKS-1:0] task_info,
   input  logic [SW-1:0]        rr_ptr,
   output logic                 found,
   output logic [SW-1:0]        slot,
   output logic [3:0]           id
);

   int         idx;
   logic [7:0] slot_byte;
   logic [3:0] best_prio;

   // Scan from rr_ptr+1 upward; only a strictly higher priority displaces the first hit
   always_comb begin
      found     = 1'b0;
      slot      = '0;
      id        = 4'h0;
      best_prio = 4'h0;
      idx       = 0;
      slot_byte = 8'h00;
      for (int k = 1; k <= N_TASKS; k++) begin
         idx       = (int'(rr_ptr) + k) % N_TASKS;
         slot_byte = task_info[8*idx +: 8];
         if ((slot_byte != 8'h00) && (!found || (slot_byte[3:0] > best_prio))) begin
            found     = 1'b1;
            best_prio = slot_byte[3:0];
            slot      = SW'(idx);
            id        = slot_byte[7:4];
         end
      end
   end

endmodule

// File: rtl/task_scheduler.sv
// rtl/task_scheduler.sv - op-bus arbiter: host forwarding, task selection, time-sliced execution
module task_scheduler
   import task_scheduler_pkg::*;
#(
   parameter int N_TASKS      = 8,
   parameter int SLICE_CYCLES = 10000,
   parameter int SW           = $clog2(N_TASKS)
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic [8*N_TASKS-1:0] task_info,
   input  logic [15:0]          host_op,
   input  logic                 host_valid,
   output logic                 host_ready,
   output logic [15:0]          op_out,
   output logic                 op_valid,
   output logic [SW-1:0]        cur_slot,
   output logic                 busy
);

   localparam int            CW         = (SLICE_CYCLES > 2) ? $clog2(SLICE_CYCLES) : 1;
   localparam logic [CW-1:0] SLICE_LAST = CW'(SLICE_CYCLES - 1);

   state_t        state_q, state_d;
   logic [15:0]   op_out_q, op_out_d;
   logic          op_valid_q, op_valid_d;
   logic          host_ready_q, host_ready_d;
   logic [SW-1:0] cur_slot_q, cur_slot_d;
   logic [3:0]    cur_id_q, cur_id_d;
   logic [SW-1:0] rr_ptr_q, rr_ptr_d;
   logic [CW-1:0] slice_cnt_q, slice_cnt_d;
   logic          busy_q, busy_d;

   logic          sel_found;
   logic [SW-1:0] sel_slot;
   logic [3:0]    sel_id;
   logic [7:0]    cur_byte;

   prio_rr_select #(
      .N_TASKS (N_TASKS),
      .SW      (SW)
   ) u_select (
      .task_info (task_info),
      .rr_ptr    (rr_ptr_q),
      .found     (sel_found),
      .slot      (sel_slot),
      .id        (sel_id)
   );

   assign cur_byte = task_info[8*int'(cur_slot_q) +: 8];

   // Next-state and registered-output values; every op is a single-cycle pulse
   always_comb begin
      state_d      = state_q;
      op_out_d     = 16'h0000;
      op_valid_d   = 1'b0;
      host_ready_d = 1'b0;
      cur_slot_d   = cur_slot_q;
      cur_id_d     = cur_id_q;
      rr_ptr_d     = rr_ptr_q;
      slice_cnt_d  = slice_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (host_ready_q) begin
               // handshake completes this cycle; forward the word next cycle
               if (host_valid) begin
                  op_out_d   = host_op;
                  op_valid_d = 1'b1;
               end
            end else if (host_valid) begin
               host_ready_d = 1'b1;
            end else if (|task_info) begin
               state_d = ST_SELECT;
            end
         end
         ST_SELECT: begin
            if (sel_found) begin
               cur_slot_d = sel_slot;
               cur_id_d   = sel_id;
               op_out_d   = make_op(sel_id, OP_EXECUTE, 4'h0);
               op_valid_d = 1'b1;
               state_d    = ST_DISPATCH;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_DISPATCH: begin
            rr_ptr_d    = cur_slot_q;
            slice_cnt_d = '0;
            state_d     = ST_RUN;
         end
         ST_RUN: begin
            if ((slice_cnt_q == SLICE_LAST) || (cur_byte == 8'h00)) begin
               op_out_d   = make_op(cur_id_q, OP_FINISH, 4'h0);
               op_valid_d = 1'b1;
               state_d    = ST_FINISH;
            end else begin
               slice_cnt_d = slice_cnt_q + 1'b1;
            end
         end
         ST_FINISH: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d == ST_DISPATCH) || (state_d == ST_RUN) || (state_d == ST_FINISH);
   end

   // State and output registers; reset clears the bus without issuing Finish
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q      <= ST_IDLE;
         op_out_q     <= 16'h0000;
         op_valid_q   <= 1'b0;
         host_ready_q <= 1'b0;
         cur_slot_q   <= '0;
         cur_id_q     <= 4'h0;
         rr_ptr_q     <= SW'(N_TASKS - 1);
         slice_cnt_q  <= '0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         op_out_q     <= op_out_d;
         op_valid_q   <= op_valid_d;
         host_ready_q <= host_ready_d;
         cur_slot_q   <= cur_slot_d;
         cur_id_q     <= cur_id_d;
         rr_ptr_q     <= rr_ptr_d;
         slice_cnt_q  <= slice_cnt_d;
         busy_q       <= busy_d;
      end
   end

   assign op_out     = op_out_q;
   assign op_valid   = op_valid_q;
   assign host_ready = host_ready_q;
   assign cur_slot   = cur_slot_q;
   assign busy       = busy_q;

endmodule
